// File: rtl/lampFPU_pkg.sv
// -----------------------------------------------------------------------------
// lampFPU_pkg
// Shared types and constants for the square-root arbiter front-end.
//   state_t      : controller FSM states (IDLE, ISSUE, WAIT, RESP)
//   cls_t        : operand classification (NORMAL, ZERO, NAN, PINF)
//   cls_res_t    : classification plus the result a special operand maps to
//   lamp_classify: unpacks a bfloat16 operand and classifies it
// -----------------------------------------------------------------------------
package lampFPU_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

   typedef enum logic [1:0] {
      NORMAL,
      ZERO,
      NAN,
      PINF
   } cls_t;

   localparam logic [8:0]  LAMP_FLOAT_E_BIAS = 9'd127;
   localparam logic [15:0] LAMP_QNAN         = 16'h7FC0;
   localparam logic [15:0] LAMP_PINF         = 16'h7F80;

   typedef struct packed {
      cls_t        cls;
      logic [15:0] res;
   } cls_res_t;

   // Priority matters: a zero exponent flushes to signed zero even when the
   // sign is set, and a negative non-zero operand (including -inf) is invalid.
   function automatic cls_res_t lamp_classify(input logic [15:0] op);
      cls_res_t   r;
      logic       s;
      logic [7:0] e;
      logic [6:0] f;
      s     = op[15];
      e     = op[14:7];
      f     = op[6:0];
      r.cls = NORMAL;
      r.res = '0;
      if (e == 8'd0) begin
         r.cls = ZERO;
         r.res = {s, 15'b0};
      end else if (e == 8'hFF && f != 7'd0) begin
         r.cls = NAN;
         r.res = LAMP_QNAN;
      end else if (s) begin
         r.cls = NAN;
         r.res = LAMP_QNAN;
      end else if (e == 8'hFF) begin
         r.cls = PINF;
         r.res = LAMP_PINF;
      end
      return r;
   endfunction

endpackage

// File: rtl/sqrt_arbiter_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches req upward from ptr,
// wrapping modulo N_REQ, and grants the first asserted requester.
//   req   in  N_REQ           request vector
//   ptr   in  clog2(N_REQ)    search start index (register owned by parent)
//   en    in  1               grant enable; grant is all-zero when low
//   grant out N_REQ           one-hot grant (or zero)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] ptr,
   input  logic                     en,
   output logic [N_REQ-1:0]         grant
);

   localparam int PW = $clog2(N_REQ);

   logic          found;
   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   always_comb begin
      grant = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         // One extra bit so ptr+i cannot overflow before the modulo wrap.
         sum = {1'b0, ptr} + (PW+1)'(i);
         if (sum >= (PW+1)'(N_REQ)) begin
            sum = sum - (PW+1)'(N_REQ);
         end
         idx = sum[PW-1:0];
         if (en && !found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sqrt_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// sqrt_arbiter_ctrl
// Shares one SquareRootModule between N_REQ requesters. Round-robin accepts
// one bfloat16 operand, classifies it, sequences the sqrt unit (doSqrt or
// special_case pulse, then waits for valid), repacks the bfloat16 result and
// returns it to the owning requester. One operation in flight at a time.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   req_valid_i     per-requester request valid
//   req_op_i        packed operands, requester k at [16k+15:16k]
//   req_ready_o     one-hot accept (combinational, IDLE only)
//   rsp_valid_o     one-hot response valid toward the owner
//   rsp_res_o       shared bfloat16 result bus
//   rsp_ready_i     per-requester response ready
//   sq_do_o         doSqrt pulse          sq_special_o  special_case pulse
//   sq_s_o          {1, frac}             sq_odd_o      unbiased exponent odd
//   sq_valid_i      sqrt unit valid       sq_res_i      sqrt unit mantissa
//   busy_o          high whenever not IDLE
//
// Optional build macro SQRT_ARB_PERF_EN adds:
//   perf_ops_o      saturating count of completed response handshakes
//   perf_maxlat_o   maximum ISSUE-to-sq_valid_i cycle count
// -----------------------------------------------------------------------------
module sqrt_arbiter_ctrl
   import lampFPU_pkg::*;
#(
   parameter int N_REQ = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      req_valid_i,
   input  logic [N_REQ*16-1:0]   req_op_i,
   output logic [N_REQ-1:0]      req_ready_o,
   output logic [N_REQ-1:0]      rsp_valid_o,
   output logic [15:0]           rsp_res_o,
   input  logic [N_REQ-1:0]      rsp_ready_i,
   output logic                  sq_do_o,
   output logic [7:0]            sq_s_o,
   output logic                  sq_odd_o,
   output logic                  sq_special_o,
   input  logic                  sq_valid_i,
   input  logic [7:0]            sq_res_i,
   output logic                  busy_o
`ifdef SQRT_ARB_PERF_EN
   ,
   output logic [31:0]           perf_ops_o,
   output logic [15:0]           perf_maxlat_o
`endif
);

   localparam int PW = $clog2(N_REQ);

   state_t        state, state_nxt;
   logic [PW-1:0] rr_ptr;
   logic [PW-1:0] owner;
   logic [14:0]   op_q;          // exponent and fraction; sign only matters to classification
   logic          special_q;
   logic [15:0]   special_res_q;

   logic [N_REQ-1:0] grant;
   logic [PW-1:0]    grant_idx;
   logic [15:0]      op_sel;
   cls_res_t         sel_cls;
   logic [8:0]       er_sum;
   logic             owner_ready;
   logic             unused_res_msb;

   // The MSB of the sqrt mantissa is the implicit 1 and is dropped on repack.
   assign unused_res_msb = sq_res_i[7];

   rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
      .req   (req_valid_i),
      .ptr   (rr_ptr),
      .en    (state == IDLE),
      .grant (grant)
   );

   assign req_ready_o = grant;
   assign busy_o      = (state != IDLE);
   assign owner_ready = rsp_ready_i[owner];
   assign sel_cls     = lamp_classify(op_sel);

   // Result exponent: (E + bias) >> 1 in 9 bits, i.e. floor((E-127)/2)+127.
   assign er_sum = {1'b0, op_q[14:7]} + LAMP_FLOAT_E_BIAS;

   always_comb begin
      grant_idx = '0;
      op_sel    = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            grant_idx = PW'(i);
            op_sel    = req_op_i[16*i +: 16];
         end
      end
   end

   // NOTE: non-blocking assignments in clocked processes so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         rr_ptr        <= '0;
         // NOTE: the operand/result datapath registers are reset as well, so an
         // aborted operation leaves nothing behind to leak into the next one.
         owner         <= '0;
         op_q          <= '0;
         special_q     <= 1'b0;
         special_res_q <= '0;
         rsp_res_o     <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (|grant) begin
                  owner         <= grant_idx;
                  op_q          <= op_sel[14:0];
                  special_q     <= (sel_cls.cls != NORMAL);
                  special_res_q <= sel_cls.res;
               end
            end
            WAIT: begin
               if (sq_valid_i) begin
                  rsp_res_o <= special_q ? special_res_q
                                         : {1'b0, er_sum[8:1], sq_res_i[6:0]};
               end
            end
            RESP: begin
               if (owner_ready) begin
                  rr_ptr    <= (owner == PW'(N_REQ-1)) ? '0 : owner + PW'(1);
                  rsp_res_o <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // NOTE: every output of this process gets a default first; a path that
   // leaves one unassigned would infer a latch.
   always_comb begin
      state_nxt    = state;
      sq_do_o      = 1'b0;
      sq_special_o = 1'b0;
      sq_s_o       = '0;
      sq_odd_o     = 1'b0;
      rsp_valid_o  = '0;
      case (state)
         IDLE: begin
            if (|grant) state_nxt = ISSUE;
         end
         ISSUE: begin
            if (special_q) begin
               sq_special_o = 1'b1;
            end else begin
               sq_do_o  = 1'b1;
               sq_s_o   = {1'b1, op_q[6:0]};
               // Unbiased exponent E-127 is odd exactly when E is even.
               sq_odd_o = ~op_q[7];
            end
            state_nxt = WAIT;
         end
         WAIT: begin
            if (sq_valid_i) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid_o[owner] = 1'b1;
            if (owner_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef SQRT_ARB_PERF_EN
   logic [15:0] lat_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_ops_o    <= '0;
         perf_maxlat_o <= '0;
         lat_cnt       <= '0;
      end else begin
         if (state == RESP && owner_ready && perf_ops_o != '1) begin
            perf_ops_o <= perf_ops_o + 32'd1;
         end
         // lat_cnt counts the ISSUE cycle as 1, then each WAIT cycle.
         if (state == ISSUE) begin
            lat_cnt <= 16'd1;
         end else if (state == WAIT) begin
            if (sq_valid_i) begin
               if (lat_cnt > perf_maxlat_o) perf_maxlat_o <= lat_cnt;
            end else if (lat_cnt != '1) begin
               lat_cnt <= lat_cnt + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_sqrt_arbiter_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sqrt_arbiter_ctrl
// Scoreboard bench: accepted requests push the expected response (computed
// from real-valued sqrt and the special-value rules), a negedge monitor pops
// and compares when the owner's response handshake happens. A small stand-in
// for SquareRootModule answers doSqrt with an integer square root after a
// random delay and answers special_case with garbage after a fixed delay.
// -----------------------------------------------------------------------------
module tb_sqrt_arbiter_ctrl;

   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
   logic [N*16-1:0] req_op;
   logic [15:0]     rsp_res;
   logic            sq_do, sq_special, sq_odd, sq_valid, busy;
   logic [7:0]      sq_s, sq_res;
`ifdef SQRT_ARB_PERF_EN
   logic [31:0]     perf_ops;
   logic [15:0]     perf_maxlat;
`endif

   always #5 clk = ~clk;

   sqrt_arbiter_ctrl #(.N_REQ(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_op_i     (req_op),
      .req_ready_o  (req_ready),
      .rsp_valid_o  (rsp_valid),
      .rsp_res_o    (rsp_res),
      .rsp_ready_i  (rsp_ready),
      .sq_do_o      (sq_do),
      .sq_s_o       (sq_s),
      .sq_odd_o     (sq_odd),
      .sq_special_o (sq_special),
      .sq_valid_i   (sq_valid),
      .sq_res_i     (sq_res),
      .busy_o       (busy)
`ifdef SQRT_ARB_PERF_EN
      ,
      .perf_ops_o   (perf_ops),
      .perf_maxlat_o(perf_maxlat)
`endif
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- stand-in sqrt unit ----------------
   int          mk_cnt  = 0;
   int          mk_d    = 0;
   int          next_d  = 5;
   int          force_d = 0;
   logic [7:0]  mk_res  = '0;
   logic        spur    = 1'b0;

   function automatic int isqrt(input int v);
      int r = 0;
      while ((r + 1) * (r + 1) <= v) r++;
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mk_cnt <= 0;
         mk_res <= '0;
      end else if (sq_do) begin
         mk_cnt <= next_d;
         mk_d   <= next_d;
         mk_res <= 8'(isqrt(sq_odd ? int'(sq_s) * 256 : int'(sq_s) * 128));
      end else if (sq_special) begin
         mk_cnt <= 3;
         mk_d   <= 3;
         mk_res <= 8'($urandom);
      end else if (mk_cnt != 0) begin
         mk_cnt <= mk_cnt - 1;
      end
   end

   assign sq_valid = (mk_cnt == 1) || spur;
   assign sq_res   = mk_res;

   // ---------------- reference model ----------------
   function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
      for (int i = 0; i < N; i++) begin
         if (v[(ptr + i) % N]) return (ptr + i) % N;
      end
      return -1;
   endfunction

   function automatic bit is_special(input logic [15:0] op);
      return (op[14:7] == 8'd0) || (op[14:7] == 8'hFF) || op[15];
   endfunction

   function automatic bit exp_odd(input logic [15:0] op);
      int x = int'(op[14:7]) - 127;
      return (x % 2) != 0;
   endfunction

   function automatic logic [15:0] ref_result(input logic [15:0] op);
      int  e  = int'(op[14:7]);
      int  f  = int'(op[6:0]);
      int  x, ex, fr;
      real v, r;
      if (e == 0)               return {op[15], 15'b0};
      if (e == 255 && f != 0)   return 16'h7FC0;
      if (op[15])               return 16'h7FC0;
      if (e == 255)             return 16'h7F80;
      v = 1.0 + f / 128.0;
      x = e - 127;
      for (int i = 0; i < x; i++) v = v * 2.0;
      for (int i = 0; i > x; i--) v = v / 2.0;
      r  = $sqrt(v);
      ex = 0;
      while (r >= 2.0) begin r = r / 2.0; ex++; end
      while (r < 1.0)  begin r = r * 2.0; ex--; end
      fr = int'($floor((r - 1.0) * 128.0));
      return {1'b0, 8'(ex + 127), 7'(fr)};
   endfunction

   function automatic logic [15:0] rand_normal();
      return {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
   endfunction

   function automatic logic [15:0] rand_op();
      logic [15:0] specials [8] = '{16'hBF80, 16'h8000, 16'h7F80, 16'h7FC1,
                                    16'h0000, 16'hFF80, 16'h0055, 16'hFF81};
      case ($urandom_range(0, 9))
         0:       return specials[$urandom_range(0, 7)];
         1:       return {1'b1, 8'($urandom_range(1, 254)), 7'($urandom)};
         default: return rand_normal();
      endcase
   endfunction

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      int          owner;
      logic [15:0] op;
      logic [15:0] expv;
      bit          special;
      int          acc_cyc;
   } sb_t;

   sb_t          sb [$];
   int           grant_log [$];
   bit           pending   = 1'b0;
   bit           in_resp   = 1'b0;
   bit           after_rst = 1'b0;
   int           ptr_m     = 0;
   int           n_ops     = 0;
   int           stall_cnt = 0;
   logic [15:0]  held      = '0;
   logic [N-1:0] acc_mask  = '0;

   always @(negedge clk) begin : monitor
      int           exp_k, lat, exp_lat, diff;
      logic [N-1:0] exp_g, own;
      sb_t          e;
      if (rst) begin
         sb.delete();
         pending   = 1'b0;
         in_resp   = 1'b0;
         ptr_m     = 0;
         after_rst = 1'b1;
      end else begin
         if (after_rst) begin
            check({req_ready, rsp_valid, rsp_res, sq_do, sq_special, sq_s, sq_odd, busy} == '0,
                  "reset_outputs",
                  64'({req_ready, rsp_valid, rsp_res, sq_do, sq_special, sq_s, sq_odd, busy}), 0);
            after_rst = 1'b0;
         end
         check(busy == pending, "busy", 64'(busy), 64'(pending));
         exp_k = pending ? -1 : rr_pick(req_valid, ptr_m);
         exp_g = '0;
         if (exp_k >= 0) exp_g[exp_k] = 1'b1;
         check(req_ready == exp_g, "grant", 64'(req_ready), 64'(exp_g));

         if (sq_do || sq_special) begin
            if (sb.size() == 0) begin
               check(1'b0, "issue_without_op", 64'({sq_do, sq_special}), 0);
            end else begin
               check(sq_special == sb[0].special && sq_do == !sb[0].special, "issue_kind",
                     64'({sq_do, sq_special}), 64'({!sb[0].special, sb[0].special}));
               if (!sb[0].special) begin
                  check(sq_s == {1'b1, sb[0].op[6:0]} && sq_odd == exp_odd(sb[0].op),
                        "issue_operand", 64'({sq_odd, sq_s}),
                        64'({exp_odd(sb[0].op), 1'b1, sb[0].op[6:0]}));
               end
            end
         end

         if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
               check(1'b0, "rsp_unexpected", 64'(rsp_valid), 0);
            end else begin
               e   = sb[0];
               own = '0;
               own[e.owner] = 1'b1;
               check(rsp_valid == own, "rsp_owner", 64'(rsp_valid), 64'(own));
               if (!in_resp) begin
                  in_resp = 1'b1;
                  held    = rsp_res;
                  lat     = cyc - (e.acc_cyc + 1);
                  exp_lat = e.special ? 4 : mk_d + 1;
                  check(lat == exp_lat, "latency", 64'(lat), 64'(exp_lat));
               end else begin
                  check(rsp_res == held, "rsp_stable", 64'(rsp_res), 64'(held));
               end
               if (!rsp_ready[e.owner]) stall_cnt++;
               if (rsp_ready[e.owner]) begin
                  diff = int'(rsp_res) - int'(e.expv);
                  check(e.special ? (rsp_res == e.expv) : (diff >= -1 && diff <= 1),
                        e.special ? "result_special" : "result_normal",
                        64'(rsp_res), 64'(e.expv));
                  void'(sb.pop_front());
                  pending = 1'b0;
                  in_resp = 1'b0;
                  ptr_m   = (e.owner + 1) % N;
                  n_ops++;
               end
            end
         end

         if (exp_k >= 0 && req_valid[exp_k] && req_ready[exp_k]) begin
            e.owner   = exp_k;
            e.op      = req_op[16*exp_k +: 16];
            e.expv    = ref_result(e.op);
            e.special = is_special(e.op);
            e.acc_cyc = cyc;
            sb.push_back(e);
            pending = 1'b1;
            acc_mask[exp_k] = 1'b1;
            grant_log.push_back(exp_k);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
      next_d = (force_d != 0) ? force_d : int'($urandom_range(3, 9));
      for (int k = 0; k < N; k++) begin
         if (acc_mask[k]) begin
            acc_mask[k]  = 1'b0;
            req_valid[k] = 1'b0;
         end
      end
   endtask

   task automatic send_one(input int k, input logic [15:0] op);
      req_op[16*k +: 16] = op;
      req_valid[k]       = 1'b1;
   endtask

   task automatic wait_quiet(input int budget);
      int c = 0;
      do begin
         step();
         c++;
      end while ((req_valid != '0 || pending) && c < budget);
      check(c < budget, "wait_quiet_timeout", 64'(c), 64'(budget));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst       = 1'b1;
      req_valid = '0;
      acc_mask  = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      step();
   endtask

   initial begin : main
      logic [15:0] spec_ops [4] = '{16'hBF80, 16'h8000, 16'h7F80, 16'h7FC1};
      int base, c;
      rst       = 1'b1;
      req_valid = '0;
      req_op    = '0;
      rsp_ready = '1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      step();

      // 4.0 from requester 0 alone, then 2.0 (odd exponent) from requester 2.
      send_one(0, 16'h4080);
      wait_quiet(200);
      send_one(2, 16'h4000);
      wait_quiet(200);

      // Special operands one at a time.
      for (int i = 0; i < 4; i++) begin
         send_one((i + 1) % N, spec_ops[i]);
         wait_quiet(200);
      end

      // All requesters valid continuously from a fresh pointer.
      do_reset();
      base = grant_log.size();
      c    = 0;
      while (grant_log.size() < base + 5 && c < 500) begin
         for (int k = 0; k < N; k++) begin
            if (!req_valid[k]) send_one(k, rand_normal());
         end
         step();
         c++;
      end
      check(c < 500, "rr_timeout", 64'(c), 500);
      for (int i = 0; i < 5; i++) begin
         if (grant_log.size() > base + i) begin
            check(grant_log[base + i] == i % N, "rr_order", 64'(grant_log[base + i]), 64'(i % N));
         end
      end
      req_valid = '0;
      wait_quiet(300);

      // Requester 1 holds off its response ready for 10 cycles.
      rsp_ready[1] = 1'b0;
      send_one(1, rand_normal());
      c = 0;
      while (!rsp_valid[1] && c < 100) begin
         step();
         c++;
      end
      check(c < 100, "stall_rsp_timeout", 64'(c), 100);
      stall_cnt = 0;
      send_one(0, rand_normal());
      send_one(2, rand_normal());
      repeat (10) step();
      rsp_ready[1] = 1'b1;
      check(stall_cnt >= 10, "stall_cycles", 64'(stall_cnt), 10);
      wait_quiet(300);

      // Leave the pointer at 3, then abort an operation in WAIT with reset.
      send_one(2, rand_normal());
      wait_quiet(200);
      force_d = 9;
      send_one(1, rand_normal());
      repeat (5) step();
      do_reset();
      force_d = 0;
      base = grant_log.size();
      send_one(3, rand_normal());
      send_one(0, rand_normal());
      wait_quiet(300);
      check(grant_log.size() > base && grant_log[base] == 0, "grant_after_reset",
            64'(grant_log.size() > base ? grant_log[base] : -1), 0);

      // Randomised traffic.
      base = n_ops;
      c    = 0;
      while (n_ops < base + 300 && c < 40000) begin
         step();
         c++;
         for (int k = 0; k < N; k++) begin
            if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
               send_one(k, rand_op());
            end else if (req_valid[k] && $urandom_range(0, 15) == 0) begin
               req_valid[k] = 1'b0;
            end
            rsp_ready[k] = ($urandom_range(0, 2) != 0);
         end
         spur = !busy && ($urandom_range(0, 5) == 0);
      end
      check(c < 40000, "random_timeout", 64'(c), 40000);
      spur      = 1'b0;
      req_valid = '0;
      rsp_ready = '1;
      wait_quiet(300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sqrt_arbiter_ctrl.md
Name: sqrt_arbiter_ctrl

Overview:
- Front-end controller that shares one SquareRootModule instance between N_REQ requesters.
- Round-robin arbitration over requesters, each presenting one bfloat16 operand.
- Unpacks the operand, classifies special cases, sequences the sqrt unit (doSqrt/special_case pulse, then wait for valid), repacks the bfloat16 result and returns it to the owning requester.
- Exactly one operation in flight at a time.

Parameters:
- N_REQ, default 4: number of requesters; range 2..8.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid_i  in  N_REQ  per-requester request valid
- req_op_i  in  N_REQ*16  packed bfloat16 operands; requester k uses bits [16k+15:16k]
- req_ready_o  out  N_REQ  one-hot accept; request k is taken when req_valid_i[k] & req_ready_o[k]
- rsp_valid_o  out  N_REQ  one-hot response valid, raised toward the owner only
- rsp_res_o  out  16  bfloat16 result, shared bus
- rsp_ready_i  in  N_REQ  per-requester response ready
- sq_do_o  out  1  to SquareRootModule doSqrt_i; 1-cycle pulse
- sq_s_o  out  8  to s_i: {1'b1, frac[6:0]}
- sq_odd_o  out  1  to is_exp_odd_i
- sq_special_o  out  1  to special_case_i; 1-cycle pulse
- sq_valid_i  in  1  from valid_o
- sq_res_i  in  8  from res_o
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=0.
  - All outputs 0: req_ready_o, rsp_valid_o, rsp_res_o, sq_* outputs, busy_o.
  - Internal latches (owner, op, special flag, special result) cleared.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o is combinational: one-hot for the first asserted req_valid_i found searching upward from rr_ptr, modulo N_REQ.
  - On accept of requester k: latch owner=k, latch the operand, classify it, go to ISSUE.
  - No valid requests: stay in IDLE and drive nothing.
- Classification (E=exp[14:7], F=frac[6:0], S=sign):
  - E==0, any F: zero, flush-to-zero; result {S,15'b0}.
  - E==255, F!=0: NaN; result 16'h7FC0.
  - S==1, nonzero: invalid; result 16'h7FC0.
  - E==255, F==0, S==0: result 16'h7F80.
  - Otherwise: normal.
- ISSUE (exactly 1 cycle):
  - Special operand: sq_special_o=1, sq_do_o=0.
  - Normal operand: sq_do_o=1, sq_s_o={1,F}, sq_odd_o=~E[0] (unbiased exponent is odd exactly when E is even).
  - Go to WAIT.
- WAIT:
  - Hold until sq_valid_i. No timeout.
  - On sq_valid_i:
    - Special: result = latched special value; sq_res_i is ignored.
    - Normal: result = {1'b0, Er, sq_res_i[6:0]} with Er = (E+127)>>1, computed in 9 bits, floor semantics.
  - Register the result into rsp_res_o and go to RESP.
- RESP:
  - rsp_valid_o[owner]=1 and rsp_res_o stable until rsp_ready_i[owner]=1.
  - On handshake: rsp_valid_o cleared, rr_ptr=(owner+1) mod N_REQ, go to IDLE.
  - Next accept can happen the cycle after the handshake, never in the same cycle.
- Latency: accept → rsp_valid is 3 cycles plus the sqrt unit's compute time. Special-case path is fixed at 4 cycles.
- sq_valid_i seen outside WAIT: ignored.
- req_valid_i deasserted while in RESP: no effect.
- rst mid-operation:
  - Aborts the operation; pending response is discarded with no rsp_valid.
  - rr_ptr returns to 0.
  - The sqrt unit shares rst, so both blocks restart clean together.
- Fairness: a continuously requesting requester is served at least once every N_REQ operations.

Optional Feature:
- Macro: SQRT_ARB_PERF_EN.
- With the macro defined, two extra output ports:
  - perf_ops_o (32 bit): completed response handshakes, saturating.
  - perf_maxlat_o (16 bit): maximum ISSUE→sq_valid_i cycle count.
  - Both reset to 0.
- Without the macro: the ports and counters do not exist; functional behaviour is identical.

Decomposition:
- lampFPU_pkg holds:
  - the state enum;
  - LAMP_FLOAT_E_BIAS (127);
  - LAMP_QNAN (16'h7FC0), LAMP_PINF (16'h7F80);
  - a classification enum {NORMAL, ZERO, NAN, PINF}.
- One sub-module: rr_arbiter (N_REQ parameter; inputs req, ptr, en; output one-hot grant). Purely combinational; rr_ptr is owned by the parent.

Test Plan:
- req_op[0]=16'h4080 (4.0) alone → req_ready_o=4'b0001; rsp_valid_o[0]; rsp_res_o=16'h4000 (tolerance ±1 ULP from the unit).
- req_op[2]=16'h4000 (2.0, odd exponent) → sq_odd_o=1 in ISSUE; rsp_res_o≈16'h3FB5 (tolerance ±1 ULP).
- Specials, one at a time:
  - 16'hBF80 → 16'h7FC0
  - 16'h8000 → 16'h8000
  - 16'h7F80 → 16'h7F80
  - 16'h7FC1 → 16'h7FC0
  - All four: sq_do_o never pulses, accept→rsp_valid = 4 cycles.
- All four requesters hold valid continuously → grant order 0,1,2,3,0; each response reaches only its owner.
- rsp_ready_i[1] held low 10 cycles → rsp_valid_o[1] and rsp_res_o stable; no new req_ready_o until the handshake.
- Assert rst for one cycle during WAIT → all outputs 0 next cycle; no rsp_valid; next request granted starting from requester 0.
